aes_128_decrypt: RTL and testbench

AES_128_DECRYPT -- requirements
Module: aes_128_decrypt

---
 rtl/aes_pkg.sv | 80 ++++++++
 rtl/aes_inv_round.sv | 55 +++++
 rtl/aes_128_decrypt.sv | 145 ++++++++++++++
 tb/tb_aes_128_decrypt.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encodings, Rcon, S-boxes and GF(2^8) helpers.
// The same package serves the encrypt and decrypt cores.
package aes_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_KEYEXP   = 3'd1;
    localparam logic [2:0] ST_INIT_ARK = 3'd2;
    localparam logic [2:0] ST_ROUND    = 3'd3;
    localparam logic [2:0] ST_FINAL    = 3'd4;

    // Multiply by x modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply, shift-and-add
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ p;
            end else begin
                acc = acc;
            end
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] res;
        logic [7:0] sq;
        res = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    // Forward S-box: inverse followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine map followed by the inverse
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] t;
        t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    // Round constant for key-schedule round 1..10
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless is_final_i is set.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    input  logic         is_final_i,
    output logic [127:0] state_o
);

    logic [127:0] ark_s;
    logic [127:0] mix_s;

    // InvMixColumns on one column {s0,s1,s2,s3}
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] s0, s1, s2, s3;
        s0 = col[31:24];
        s1 = col[23:16];
        s2 = col[15:8];
        s3 = col[7:0];
        return {gf_mul(s0, 8'h0e) ^ gf_mul(s1, 8'h0b) ^ gf_mul(s2, 8'h0d) ^ gf_mul(s3, 8'h09),
                gf_mul(s0, 8'h09) ^ gf_mul(s1, 8'h0e) ^ gf_mul(s2, 8'h0b) ^ gf_mul(s3, 8'h0d),
                gf_mul(s0, 8'h0d) ^ gf_mul(s1, 8'h09) ^ gf_mul(s2, 8'h0e) ^ gf_mul(s3, 8'h0b),
                gf_mul(s0, 8'h0b) ^ gf_mul(s1, 8'h0d) ^ gf_mul(s2, 8'h09) ^ gf_mul(s3, 8'h0e)};
    endfunction

    // Byte i sits at row i%4, column i/4; row r takes its byte from column (c-r) mod 4
    always_comb begin
        ark_s = 128'h0;
        for (int i = 0; i < 16; i++) begin
            ark_s[127-8*i -: 8] =
                inv_sbox(state_i[127-8*((((i/4)-(i%4)+4)%4)*4+(i%4)) -: 8])
                ^ round_key_i[127-8*i -: 8];
        end
    end

    // Column mixing of the key-added state
    always_comb begin
        mix_s = 128'h0;
        for (int c = 0; c < 4; c++) begin
            mix_s[127-32*c -: 32] = inv_mix_col(ark_s[127-32*c -: 32]);
        end
    end

    // Last round skips InvMixColumns
    always_comb begin
        if (is_final_i) begin
            state_o = ark_s;
        end else begin
            state_o = mix_s;
        end
    end

endmodule

// File: rtl/aes_128_decrypt.sv
// Iterative AES-128 inverse cipher, one round per clock. The key schedule is
// run forward to K10 and then stepped back in place each round.
module aes_128_decrypt
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start_decrypt,
    input  logic [127:0] ciphertext_in,
    input  logic [127:0] key_in,
    output logic [127:0] plaintext_out,
    output logic         decrypt_done,
    output logic         busy
);

    logic [2:0]   state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] key_q, key_d;
    logic [127:0] data_q, data_d;
    logic [127:0] pt_q, pt_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
    logic [127:0] round_out_s;
    logic         is_final_s;

    // SubWord(RotWord(w))
    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    // K(r-1) -> K(r)
    function automatic logic [127:0] fwd_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h000000};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // K(r) -> K(r-1), using Rcon[r]
    function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_rot(p3) ^ {rc, 24'h000000};
        return {p0, p1, p2, p3};
    endfunction

    assign is_final_s = (state_q == ST_FINAL);

    aes_inv_round u_inv_round (
        .state_i     (data_q),
        .round_key_i (key_q),
        .is_final_i  (is_final_s),
        .state_o     (round_out_s)
    );

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        ct_d    = ct_q;
        key_d   = key_q;
        data_d  = data_q;
        pt_d    = pt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_decrypt) begin
                    ct_d    = ciphertext_in;
                    key_d   = key_in;
                    rnd_d   = 4'd0;
                    state_d = ST_KEYEXP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_KEYEXP: begin
                key_d = fwd_key_step(key_q, rcon(rnd_q + 4'd1));
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == 4'd9) begin
                    state_d = ST_INIT_ARK;
                end else begin
                    state_d = ST_KEYEXP;
                end
            end
            ST_INIT_ARK: begin
                data_d  = ct_q ^ key_q;
                key_d   = inv_key_step(key_q, rcon(rnd_q));
                rnd_d   = 4'd9;
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                data_d = round_out_s;
                key_d  = inv_key_step(key_q, rcon(rnd_q));
                rnd_d  = rnd_q - 4'd1;
                if (rnd_q == 4'd1) begin
                    state_d = ST_FINAL;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_FINAL: begin
                pt_d    = round_out_s;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rnd_q   <= 4'd0;
            ct_q    <= 128'h0;
            key_q   <= 128'h0;
            data_q  <= 128'h0;
            pt_q    <= 128'h0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            ct_q    <= ct_d;
            key_q   <= key_d;
            data_q  <= data_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign plaintext_out = pt_q;
    assign decrypt_done  = done_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_aes_128_decrypt.sv
// Directed-vector bench for aes_128_decrypt.
module tb_aes_128_decrypt;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_decrypt;
    logic [127:0] ciphertext_in;
    logic [127:0] key_in;
    logic [127:0] plaintext_out;
    logic         decrypt_done;
    logic         busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        string        name;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    aes_128_decrypt dut (
        .clk           (clk),
        .rst           (rst),
        .start_decrypt (start_decrypt),
        .ciphertext_in (ciphertext_in),
        .key_in        (key_in),
        .plaintext_out (plaintext_out),
        .decrypt_done  (decrypt_done),
        .busy          (busy)
    );

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start one decryption; k-th negedge after T0 shows what edge T0+k samples.
    // busy_k != 0 injects a second start with other data while busy.
    task automatic run_vec(input logic [127:0] key, input logic [127:0] ct,
                           input logic [127:0] exp, input string name, input int busy_k);
        int first_k;
        int ndone;
        first_k = 0;
        ndone   = 0;
        @(negedge clk);
        ciphertext_in = ct;
        key_in        = key;
        start_decrypt = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start_decrypt = 1'b0;
                ciphertext_in = ~ct;
                key_in        = {key[63:0], key[127:64]};
                check_int({name, " busy_after_start"}, int'(busy), 1);
            end
            if (busy_k != 0 && k == busy_k) begin
                start_decrypt = 1'b1;
                ciphertext_in = vecs[1].ct;
                key_in        = vecs[1].key;
            end
            if (busy_k != 0 && k == busy_k + 1) begin
                start_decrypt = 1'b0;
            end
            if (decrypt_done) begin
                ndone++;
                if (first_k == 0) first_k = k;
            end
            if (k == 23) begin
                check_int({name, " busy_after_done"}, int'(busy), 0);
            end
        end
        check_int({name, " latency"}, first_k, 22);
        check_int({name, " done_pulses"}, ndone, 1);
        check128({name, " plaintext"}, plaintext_out, exp);
    endtask

    initial begin
        int ndone;
        int k1;
        int k2;
        logic [127:0] pt_first;

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    128'h00112233445566778899aabbccddeeff, "C1"};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734, "AppB"};
        vecs[2] = '{128'h00000000000000000000000000000000, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                    128'h00000000000000000000000000000000, "ZeroKey"};
        vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                    128'h6bc1bee22e409f96e93d7e117393172a, "ECB1"};

        rst           = 1'b1;
        start_decrypt = 1'b0;
        ciphertext_in = 128'h0;
        key_in        = 128'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check128("reset plaintext", plaintext_out, 128'h0);
        check_int("reset done", int'(decrypt_done), 0);
        check_int("reset busy", int'(busy), 0);

        // start during reset is ignored
        start_decrypt = 1'b1;
        ciphertext_in = vecs[0].ct;
        key_in        = vecs[0].key;
        @(negedge clk);
        check_int("start_in_reset busy", int'(busy), 0);
        start_decrypt = 1'b0;
        rst           = 1'b0;
        @(negedge clk);
        check_int("start_in_reset idle", int'(busy), 0);

        // table vectors
        for (int v = 0; v < 4; v++) begin
            run_vec(vecs[v].key, vecs[v].ct, vecs[v].pt, vecs[v].name, 0);
        end

        // start while busy is ignored
        run_vec(vecs[0].key, vecs[0].ct, vecs[0].pt, "BusyStart", 5);

        // mid-operation reset
        ndone = 0;
        @(negedge clk);
        ciphertext_in = vecs[0].ct;
        key_in        = vecs[0].key;
        start_decrypt = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) start_decrypt = 1'b0;
            if (k == 12) rst = 1'b1;
            if (k == 14) rst = 1'b0;
            if (decrypt_done) ndone++;
            if (k == 13) begin
                check128("midreset plaintext", plaintext_out, 128'h0);
                check_int("midreset done", int'(decrypt_done), 0);
                check_int("midreset busy", int'(busy), 0);
            end
        end
        check_int("midreset no_done", ndone, 0);
        run_vec(vecs[0].key, vecs[0].ct, vecs[0].pt, "AfterReset", 0);

        // back-to-back: second start in the done cycle
        k1 = 0;
        k2 = 0;
        pt_first = 128'h0;
        @(negedge clk);
        ciphertext_in = vecs[0].ct;
        key_in        = vecs[0].key;
        start_decrypt = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) start_decrypt = 1'b0;
            if (k1 != 0 && k == k1 + 1) begin
                start_decrypt = 1'b0;
                ciphertext_in = 128'h0;
                key_in        = 128'h0;
            end
            if (decrypt_done) begin
                if (k1 == 0) begin
                    k1            = k;
                    pt_first      = plaintext_out;
                    start_decrypt = 1'b1;
                    ciphertext_in = vecs[1].ct;
                    key_in        = vecs[1].key;
                end else if (k2 == 0) begin
                    k2 = k;
                end
            end
        end
        check_int("b2b first_latency", k1, 22);
        check_int("b2b spacing", k2 - k1, 22);
        check128("b2b first plaintext", pt_first, vecs[0].pt);
        check128("b2b second plaintext", plaintext_out, vecs[1].pt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
